// File: rtl/fir_pkg.sv
// Shared types and sizing helpers for the FIR multiply-accumulate engine.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READY,
        MAC,
        OUT
    } state_t;

    // Index width for an n-entry structure; never narrower than one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int acc_width(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// One channel's circular sample history; tap k returns the sample written k writes ago.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAPS   = 8,
    localparam int PW    = ptr_width(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [PW-1:0]            tap,
    output logic signed [DATA_W-1:0] rdata
);

    logic signed [DATA_W-1:0] mem_reg [TAPS];
    logic [PW-1:0]            ptr_reg;
    logic [PW:0]              rd_sum;
    logic [PW-1:0]            rd_idx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_reg <= '0;
            for (int i = 0; i < TAPS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[ptr_reg] <= wdata;
            ptr_reg          <= (ptr_reg == PW'(TAPS - 1)) ? '0 : ptr_reg + 1'b1;
        end
    end

    // ptr_reg points one past the newest sample, so newest-minus-k is ptr-1-k modulo TAPS.
    assign rd_sum = (PW+1)'(ptr_reg) + (PW+1)'(TAPS - 1) - (PW+1)'(tap);
    assign rd_idx = (rd_sum >= (PW+1)'(TAPS)) ? PW'(rd_sum - (PW+1)'(TAPS)) : PW'(rd_sum);
    assign rdata  = mem_reg[rd_idx];

endmodule

// File: rtl/fir_mac_engine.sv
// Multi-channel FIR filter, one multiply-accumulate per cycle with valid/ready handshakes.
// Define FIR_SATURATE_EN to clamp results (and flag it) instead of wrapping them.
module fir_mac_engine
    import fir_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int COEF_W   = 16,
    parameter int TAPS     = 8,
    parameter int CHANNELS = 2,
    parameter int SHIFT    = 15,
    localparam int PW      = ptr_width(TAPS),
    localparam int CW      = ptr_width(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn,
    input  logic              coef_we,
    input  logic [PW-1:0]     coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CW-1:0]     in_chan,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CW-1:0]     out_chan,
    output logic              busy,
    output logic              sat_flag,
    output logic              chan_err
);

    localparam int AW    = acc_width(DATA_W, COEF_W, TAPS);
    localparam int PRODW = DATA_W + COEF_W;

    state_t                   state_reg;
    logic                     btn_prev_reg;
    logic signed [COEF_W-1:0] coef_reg [TAPS];
    logic [PW-1:0]            tap_reg;
    logic [CW-1:0]            chan_reg;
    logic signed [AW-1:0]     acc_reg;
    logic [DATA_W-1:0]        out_data_reg;
    logic [CW-1:0]            out_chan_reg;
    logic                     sat_reg;
    logic                     chan_err_reg;

    logic                     transfer;
    logic                     chan_ok;
    logic                     coef_open;
    logic                     last_tap;
    logic signed [DATA_W-1:0] tap_data [CHANNELS];
    logic signed [DATA_W-1:0] sample;
    logic signed [PRODW-1:0]  prod;
    logic signed [AW-1:0]     acc_sum;
    logic [DATA_W-1:0]        result;
    logic                     sat_hit;

    assign in_ready  = (state_reg == READY);
    assign transfer  = in_ready && in_valid;
    assign chan_ok   = (int'(in_chan) < CHANNELS);
    assign coef_open = (state_reg == IDLE) || (state_reg == READY);
    assign last_tap  = (tap_reg == PW'(TAPS - 1));

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            fir_delay_line #(
                .DATA_W (DATA_W),
                .TAPS   (TAPS)
            ) u_line (
                .clk   (clk),
                .rst   (rst),
                .we    (transfer && chan_ok && (in_chan == CW'(gi))),
                .wdata (in_data),
                .tap   (tap_reg),
                .rdata (tap_data[gi])
            );
        end
    endgenerate

    assign sample  = tap_data[chan_reg];
    assign prod    = sample * coef_reg[tap_reg];
    assign acc_sum = acc_reg + {{(AW - PRODW){prod[PRODW-1]}}, prod};

`ifdef FIR_SATURATE_EN
    logic signed [AW-1:0] shifted;
    assign shifted = acc_sum >>> SHIFT;

    // In range only when every bit from the output sign bit upward agrees.
    always_comb begin
        sat_hit = !((&shifted[AW-1:DATA_W-1]) || !(|shifted[AW-1:DATA_W-1]));
        if (sat_hit) begin
            result = shifted[AW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            result = shifted[DATA_W-1:0];
        end
    end
`else
    assign sat_hit = 1'b0;
    assign result  = DATA_W'(acc_sum >>> SHIFT);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            btn_prev_reg <= 1'b0;
            tap_reg      <= '0;
            chan_reg     <= '0;
            acc_reg      <= '0;
            out_data_reg <= '0;
            out_chan_reg <= '0;
            sat_reg      <= 1'b0;
            chan_err_reg <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                coef_reg[i] <= '0;
            end
        end else begin
            btn_prev_reg <= btn;
            // Coefficients are frozen while a result is being computed or presented.
            if (coef_we && coef_open && (int'(coef_addr) < TAPS)) begin
                coef_reg[coef_addr] <= coef_data;
            end
            case (state_reg)
                IDLE: begin
                    if (btn_prev_reg && !btn) begin
                        state_reg <= READY;
                    end
                end
                READY: begin
                    if (in_valid) begin
                        if (chan_ok) begin
                            chan_reg  <= in_chan;
                            tap_reg   <= '0;
                            acc_reg   <= '0;
                            state_reg <= MAC;
                        end else begin
                            chan_err_reg <= 1'b1;
                        end
                    end
                end
                MAC: begin
                    acc_reg <= acc_sum;
                    if (last_tap) begin
                        tap_reg      <= '0;
                        out_data_reg <= result;
                        out_chan_reg <= chan_reg;
                        sat_reg      <= sat_reg | sat_hit;
                        state_reg    <= OUT;
                    end else begin
                        tap_reg <= tap_reg + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_reg <= READY;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign out_valid = (state_reg == OUT);
    assign busy      = (state_reg == MAC) || (state_reg == OUT);
    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign sat_flag  = sat_reg;
    assign chan_err  = chan_err_reg;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: vector table, hand sequences and a randomized run
// against a sample-history model. CHANNELS=3 so the 2-bit channel field can carry an illegal code.
module tb_fir_mac_engine;

    localparam int TAPS  = 8;
    localparam int CH    = 3;
    localparam int SHIFT = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn = 1'b1;
    logic        coef_we = 1'b0;
    logic [2:0]  coef_addr = '0;
    logic [15:0] coef_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [1:0]  in_chan = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  out_chan;
    logic        busy;
    logic        sat_flag;
    logic        chan_err;

    fir_mac_engine #(
        .DATA_W   (16),
        .COEF_W   (16),
        .TAPS     (TAPS),
        .CHANNELS (CH),
        .SHIFT    (SHIFT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_chan   (in_chan),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .busy      (busy),
        .sat_flag  (sat_flag),
        .chan_err  (chan_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int x;
        int exp;
    } vec_t;

    vec_t   vecs[24];
    int     checks = 0;
    int     failures = 0;
    longint mcoef[TAPS];
    longint hist[CH][TAPS];
    bit     msat;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) mcoef[k] = 0;
        for (int c = 0; c < CH; c++)
            for (int k = 0; k < TAPS; k++) hist[c][k] = 0;
        msat = 1'b0;
    endtask

    task automatic model_push(input int ch, input longint x);
        for (int k = TAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
        hist[ch][0] = x;
    endtask

    // Direct convolution of the channel's history with the coefficient set.
    function automatic longint model_out(input int ch, output bit sat);
        longint s;
        s = 0;
        sat = 1'b0;
        for (int k = 0; k < TAPS; k++) s += mcoef[k] * hist[ch][k];
        s = s >>> SHIFT;
`ifdef FIR_SATURATE_EN
        if (s > 32767) begin
            s = 32767;
            sat = 1'b1;
        end else if (s < -32768) begin
            s = -32768;
            sat = 1'b1;
        end
`else
        s = longint'($signed(s[15:0]));
`endif
        return s;
    endfunction

    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = 16'(d);
        tick();
        coef_we = 1'b0;
        mcoef[a] = longint'($signed(16'(d)));
    endtask

    task automatic arm();
        btn = 1'b1;
        tick();
        btn = 1'b0;
        tick();
        btn = 1'b1;
        check("armed_in_ready", in_ready, 1);
    endtask

    // Transfers one sample (optionally with a same-cycle coefficient write), pokes an
    // ignored coefficient write mid-MAC, and waits for out_valid.
    task automatic send(input int ch, input int x, input bit we, input int wa, input int wd,
                        output longint got, output int gch, output int lat);
        int guard;
        guard     = 0;
        in_valid  = 1'b1;
        in_data   = 16'(x);
        in_chan   = 2'(ch);
        coef_we   = we;
        coef_addr = 3'(wa);
        coef_data = 16'(wd);
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        if (we) mcoef[wa] = longint'($signed(16'(wd)));
        model_push(ch, longint'($signed(16'(x))));
        lat = 1;
        while (!out_valid && lat < 40) begin
            if (lat == 3) begin
                coef_we   = 1'b1;
                coef_addr = 3'($urandom);
                coef_data = 16'($urandom);
            end
            tick();
            coef_we = 1'b0;
            lat++;
        end
        got = longint'($signed(out_data));
        gch = int'(out_chan);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        check("ready_after_out", in_ready, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_chan"}, out_chan, 0);
        check({tag, "_sat_flag"}, sat_flag, 0);
        check({tag, "_chan_err"}, chan_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint got, e;
        int     gch, lat, bad, ch, x;
        bit     s, same;

        // Impulse on ch0 with coef k+1, then ch1 impulse interleaved with ch0 zeros.
        for (int i = 0; i < 8; i++) vecs[i] = '{0, (i == 0) ? 1 : 0, i + 1};
        for (int j = 0; j < 8; j++) begin
            vecs[8 + 2*j] = '{1, (j == 0) ? 1 : 0, j + 1};
            vecs[9 + 2*j] = '{0, 0, 0};
        end

        rst = 1'b0;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b1;
        model_reset();

        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (in_ready || out_valid) bad++;
        end
        in_valid = 1'b0;
        check("no_press_idle", bad, 0);

        for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
        arm();

        for (int i = 0; i < 24; i++) begin
            send(vecs[i].ch, vecs[i].x, 1'b0, 0, 0, got, gch, lat);
            e = model_out(vecs[i].ch, s);
            msat |= s;
            check($sformatf("vec%0d_data", i), got, vecs[i].exp);
            check($sformatf("vec%0d_chan", i), gch, vecs[i].ch);
            check($sformatf("vec%0d_latency", i), lat, TAPS + 1);
            $display("vec %0d: chan=%0d in=%0d out=%0d exp=%0d lat=%0d", i, vecs[i].ch, vecs[i].x, got, vecs[i].exp, lat);
            handshake();
        end

        check("chan_err_clear", chan_err, 0);
        in_valid = 1'b1;
        in_chan  = 2'd3;
        in_data  = 16'd77;
        tick();
        in_valid = 1'b0;
        check("chan_err_set", chan_err, 1);
        check("illegal_stays_ready", in_ready, 1);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid || busy) bad++;
        end
        check("illegal_no_output", bad, 0);

        out_ready = 1'b0;
        send(0, 5, 1'b0, 0, 0, got, gch, lat);
        e = model_out(0, s);
        msat |= s;
        check("bp_data", got, e);
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!out_valid || longint'($signed(out_data)) != e || out_chan != 2'd0 || in_ready || !busy) bad++;
        end
        check("bp_hold", bad, 0);
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        $display("backpressure: out=%0d exp=%0d", got, e);

        check("sat_flag_pre", sat_flag, 0);
        for (int k = 0; k < TAPS; k++) write_coef(k, 'h7FFF);
        for (int n = 0; n < TAPS; n++) begin
            send(2, 'h7FFF, 1'b0, 0, 0, got, gch, lat);
            e = model_out(2, s);
            msat |= s;
            check($sformatf("big%0d_data", n), got, e);
            $display("big %0d: out=%0d exp=%0d", n, got, e);
            handshake();
        end
`ifdef FIR_SATURATE_EN
        check("sat_final", got, 32767);
        check("sat_flag", sat_flag, 1);
`else
        check("wrap_final", got, 8);
        check("sat_flag", sat_flag, 0);
`endif

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) write_coef($urandom_range(0, 7), int'($urandom));
            same = ($urandom_range(0, 3) == 0);
            ch   = $urandom_range(0, CH - 1);
            x    = int'($urandom);
            send(ch, x, same, $urandom_range(0, 7), int'($urandom), got, gch, lat);
            e = model_out(ch, s);
            msat |= s;
            check($sformatf("rand%0d_data", t), got, e);
            check($sformatf("rand%0d_chan", t), gch, ch);
            check($sformatf("rand%0d_latency", t), lat, TAPS + 1);
            $display("rand %0d: chan=%0d in=%0d out=%0d exp=%0d", t, ch, $signed(16'(x)), got, e);
            handshake();
        end
        check("rand_sat_flag", sat_flag, longint'(msat));

        in_valid = 1'b1;
        in_chan  = 2'd0;
        in_data  = 16'd100;
        tick();
        in_valid = 1'b0;
        check("mid_mac_busy", busy, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_zero_outputs("mid_mac_reset");
        rst = 1'b1;
        model_reset();
        in_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (in_ready || busy) bad++;
        end
        in_valid = 1'b0;
        check("no_rearm_without_press", bad, 0);
        arm();
        send(0, 1, 1'b0, 0, 0, got, gch, lat);
        check("post_reset_impulse", got, 0);
        check("post_reset_latency", lat, TAPS + 1);
        $display("post-reset impulse: out=%0d exp=0", got);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
